// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard and stall controller: generates the write enables and
// bubble flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It handles memory
// wait freezes (with a timeout watchdog), taken branches, load-use hazards
// and multi-cycle multiplies. It also keeps a saturating count of frontend
// stall cycles.
module pipe_stall_ctrl #(
    parameter int unsigned MUL_LAT     = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rgS1_index,
    input  logic [4:0]  id_rgS2_index,
    input  logic        id_uses_s1,
    input  logic        id_uses_s2,
    input  logic        ex_ld_ins,
    input  logic [4:0]  ex_rgD_index,
    input  logic        ex_mul_ins,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // A single-cycle multiply never enters MUL_BUSY; the load value is then unused.
    localparam logic          MUL_MULTI  = (MUL_LAT > 32'd1);
    localparam int unsigned   MUL_LOAD_I = (MUL_LAT > 32'd1) ? (MUL_LAT - 32'd2) : 32'd0;
    localparam logic [3:0]    MUL_LOAD   = MUL_LOAD_I[3:0];
    localparam int unsigned   WAIT_LAST_I = MEM_TIMEOUT - 32'd1;
    localparam logic [15:0]   WAIT_LAST  = WAIT_LAST_I[15:0];

    state_t      state_r;
    state_t      state_n;
    logic [3:0]  mul_cnt_r;
    logic [3:0]  mul_cnt_n;
    logic [15:0] wait_cnt_r;
    logic        freeze_s;
    logic        load_use_s;

    // Hazard detection: memory wait and load-use dependency (register 0 never hazards).
    always_comb begin
        freeze_s   = mem_req & ~mem_ready;
        load_use_s = ex_ld_ins & (ex_rgD_index != 5'd0) &
                     ((id_uses_s1 & (id_rgS1_index == ex_rgD_index)) |
                      (id_uses_s2 & (id_rgS2_index == ex_rgD_index)));
    end

    // Priority-ordered enable/flush generation and next-state logic.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_n      = state_r;
        mul_cnt_n    = mul_cnt_r;

        if (reset) begin
            // Hold the whole pipe as bubbles while reset is asserted.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_n      = RUN;
            mul_cnt_n    = 4'd0;
        end else if (freeze_s) begin
            // Freeze everything upstream of WB; WB receives a bubble. State holds.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_mul_ins && MUL_MULTI) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                        mul_cnt_n    = MUL_LOAD;
                        state_n      = MUL_BUSY;
                    end else if (load_use_s) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt_r != 4'd0) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                        mul_cnt_n    = mul_cnt_r - 4'd1;
                    end else begin
                        // Release cycle: the multiply result moves on to MEM.
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n   = RUN;
                    mul_cnt_n = 4'd0;
                end
            endcase
        end
    end

    // State, counters, sticky timeout flag and stall statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= RUN;
            mul_cnt_r    <= 4'd0;
            wait_cnt_r   <= 16'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state_r   <= state_n;
            mul_cnt_r <= mul_cnt_n;
            if (freeze_s) begin
                if (wait_cnt_r != 16'hFFFF) begin
                    wait_cnt_r <= wait_cnt_r + 16'd1;
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
                if (wait_cnt_r == WAIT_LAST) begin
                    mem_timeout <= 1'b1;
                end else begin
                    mem_timeout <= mem_timeout;
                end
            end else begin
                wait_cnt_r  <= 16'd0;
                mem_timeout <= mem_timeout;
            end
            if (!pc_we && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed hazard scenarios followed
// by randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    localparam int ML = 4;
    localparam int MT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rgS1_index, id_rgS2_index, ex_rgD_index;
    logic        id_uses_s1, id_uses_s2, ex_ld_ins, ex_mul_ins, ex_br_taken;
    logic        mem_req, mem_ready;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: how many EX cycles the current multiply has used (0 = none).
    int m_occ   = 0;
    int m_wait  = 0;
    int m_to    = 0;
    int m_stall = 0;

    pipe_stall_ctrl #(.MUL_LAT(ML), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .id_rgS1_index(id_rgS1_index), .id_rgS2_index(id_rgS2_index),
        .id_uses_s1(id_uses_s1), .id_uses_s2(id_uses_s2),
        .ex_ld_ins(ex_ld_ins), .ex_rgD_index(ex_rgD_index),
        .ex_mul_ins(ex_mul_ins), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        reset = 1'b0;
        id_rgS1_index = 5'd0; id_rgS2_index = 5'd0; ex_rgD_index = 5'd0;
        id_uses_s1 = 1'b0; id_uses_s2 = 1'b0; ex_ld_ins = 1'b0;
        ex_mul_ins = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // One cycle: predict, compare at the falling edge, advance the model, cross the rising edge.
    task automatic run_cycle(input string tag);
        logic [7:0] exp_v;
        logic       lu;
        int         k;
        lu = ex_ld_ins && (ex_rgD_index != 5'd0) &&
             ((id_uses_s1 && id_rgS1_index == ex_rgD_index) ||
              (id_uses_s2 && id_rgS2_index == ex_rgD_index));
        // exp_v = {pc, if_id, id_ex, ex_mem write enables, if_id, id_ex, ex_mem, mem_wb flushes}
        if (reset) begin
            exp_v = 8'b0000_1111;
        end else if (mem_req && !mem_ready) begin
            exp_v = 8'b0000_0001;
        end else if (m_occ > 0) begin
            k = m_occ + 1;
            exp_v = (k < ML) ? 8'b0001_0010 : 8'b1111_0000;
        end else if (ex_br_taken) begin
            exp_v = 8'b1111_1100;
        end else if (ex_mul_ins && ML > 1) begin
            exp_v = 8'b0001_0010;
        end else if (lu) begin
            exp_v = 8'b0011_0100;
        end else begin
            exp_v = 8'b1111_0000;
        end

        @(negedge clk);
        check_eq({tag, "_ctl"}, {24'd0, pc_we, if_id_we, id_ex_we, ex_mem_we,
                                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
                 {24'd0, exp_v});
        check_eq({tag, "_to"}, {31'd0, mem_timeout}, m_to);
        check_eq({tag, "_stall"}, {16'd0, stall_cycles}, m_stall);

        if (reset) begin
            m_occ = 0; m_wait = 0; m_to = 0; m_stall = 0;
        end else begin
            if (mem_req && !mem_ready) begin
                if (m_wait + 1 >= MT) m_to = 1;
                m_wait++;
            end else begin
                m_wait = 0;
                if (m_occ > 0) begin
                    k = m_occ + 1;
                    m_occ = (k < ML) ? k : 0;
                end else if (!ex_br_taken && ex_mul_ins && ML > 1) begin
                    m_occ = 1;
                end
            end
            if (!exp_v[7] && m_stall < 65535) m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset outputs.
        run_cycle("rst");
        set_idle();
        run_cycle("idle");

        // Load-use on S2 with rgD=5: one bubble, one stall cycle.
        ex_ld_ins = 1'b1; ex_rgD_index = 5'd5; id_uses_s2 = 1'b1; id_rgS2_index = 5'd5;
        run_cycle("lu");
        set_idle();
        run_cycle("lu_after");
        check_eq("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);

        // Branch overrides a simultaneous load-use.
        ex_ld_ins = 1'b1; ex_rgD_index = 5'd7; id_uses_s1 = 1'b1; id_rgS1_index = 5'd7;
        ex_br_taken = 1'b1;
        run_cycle("br_lu");
        set_idle();

        // Register 0 never produces a hazard.
        ex_ld_ins = 1'b1; ex_rgD_index = 5'd0; id_uses_s1 = 1'b1; id_rgS1_index = 5'd0;
        run_cycle("zero_reg");
        set_idle();

        // Multiply: 3 stall cycles, release, then RUN.
        reset = 1'b1; run_cycle("rst2"); set_idle();
        ex_mul_ins = 1'b1;
        for (int i = 0; i < ML; i++) run_cycle("mul");
        set_idle();
        run_cycle("mul_done");
        check_eq("mul_stall_cnt", {16'd0, stall_cycles}, 32'd3);

        // Memory freeze in the middle of a multiply with one stall cycle left.
        reset = 1'b1; run_cycle("rst3"); set_idle();
        ex_mul_ins = 1'b1;
        run_cycle("mf_start");
        run_cycle("mf_busy");
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("mf_frz");
        mem_ready = 1'b1;
        run_cycle("mf_last");
        mem_req = 1'b0;
        run_cycle("mf_rel");
        set_idle();
        run_cycle("mf_run");

        // Timeout: freeze held 6 cycles; flag sticks until reset.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle("to_frz");
        set_idle();
        run_cycle("to_sticky");
        check_eq("to_held", {31'd0, mem_timeout}, 32'd1);
        // Reset in the middle of a multiply aborts it and clears everything.
        ex_mul_ins = 1'b1;
        run_cycle("to_mul0");
        run_cycle("to_mul1");
        reset = 1'b1;
        run_cycle("to_rst");
        set_idle();
        run_cycle("to_clear");
        check_eq("to_cleared", {31'd0, mem_timeout}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 59) == 0);
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_ready     = $urandom_range(0, 1) == 1;
            ex_br_taken   = ($urandom_range(0, 6) == 0);
            ex_mul_ins    = !ex_br_taken && ($urandom_range(0, 7) == 0);
            ex_ld_ins     = !ex_mul_ins && ($urandom_range(0, 1) == 1);
            ex_rgD_index  = 5'($urandom_range(0, 3));
            id_rgS1_index = 5'($urandom_range(0, 3));
            id_rgS2_index = 5'($urandom_range(0, 3));
            id_uses_s1    = $urandom_range(0, 1) == 1;
            id_uses_s2    = $urandom_range(0, 1) == 1;
            run_cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
